gpu_fbuf_fill_arbiter: RTL and testbench
========================================

# gpu_fbuf_fill_arbiter

Owns the framebuffer BRAM write port and shares it between two requesters: single-pixel writes from the AXI4-Lite GPU register decoder, and a built-in rectangle-fill sequencer. The fill sequencer walks a clipped rectangle in raster order and issues one BRAM write per cycle. The block sits between the register decoder and the framebuffer BRAM write port (port A).

## Interface

**Parameters**
- FRAME_WIDTH_SCALED, 640: frame width in pixels; row stride.
- FRAME_HEIGHT_SCALED, 480: frame height in pixels.
- FBUF_ADDR_WIDTH, 19: BRAM address width.
- FBUF_DATA_WIDTH, 8: pixel width.

**Ports**
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system/AXI clock.
  - rst_n  in  1  asynchronous active-low reset.
- Pixel-write requester:
  - pix_req  in  1  single-cycle pixel write request from the decoder.
  - pix_addr  in  FBUF_ADDR_WIDTH  linear pixel address.
  - pix_data  in  FBUF_DATA_WIDTH  pixel value.
- Fill command:
  - fill_start  in  1  fill command strobe.
  - fill_x0, fill_y0  in  12 each  top-left corner, inclusive.
  - fill_x1, fill_y1  in  12 each  bottom-right corner, inclusive.
  - fill_color  in  FBUF_DATA_WIDTH  fill value.
- Fill status:
  - fill_busy  out  1  high while the FSM is not in IDLE.
  - fill_done  out  1  one-cycle completion pulse.
- Framebuffer port (registered):
  - fbuf_en_wr  out  1  BRAM enable.
  - fbuf_wrea  out  1  BRAM write enable; always equal to fbuf_en_wr.
  - fbuf_addr  out  FBUF_ADDR_WIDTH  write address.
  - fbuf_data  out  FBUF_DATA_WIDTH  write data.

## Operation

- **FSM states:** IDLE, FILL, DONE.
- **IDLE:**
  - fill_start is sampled only in IDLE.
  - On fill_start, each coordinate is clamped: x values ≥ FRAME_WIDTH_SCALED become FRAME_WIDTH_SCALED−1; y values ≥ FRAME_HEIGHT_SCALED become FRAME_HEIGHT_SCALED−1.
  - The block then latches the clamped bounds and fill_color, and loads cx=x0, cy=y0, row_base=y0·FRAME_WIDTH_SCALED.
  - If x0>x1 or y0>y1 after clamping, the next state is DONE (no writes). Otherwise the next state is FILL.
- **FILL:** each cycle without pix_req:
  - Register a write with fbuf_addr=row_base+cx and fbuf_data=fill_color.
  - If cx<x1: cx++.
  - Otherwise: cx=x0, cy++, row_base+=FRAME_WIDTH_SCALED. The multiply happens only at command capture.
  - After the write at (x1,y1), go to DONE.
- **DONE:** fill_done=1 for exactly this one cycle, then return to IDLE.
- **Arbitration:** fixed priority, pixel path wins.
  - pix_req is always accepted and is never dropped or delayed.
  - A pix_req cycle registers the pixel write, and the fill sequencer holds cx/cy/row_base unchanged (stall).
- **Commands while busy:** fill_start while fill_busy=1 is ignored; the latched command is unaffected.
- **Idle port:** with no pix_req and not writing fill data, fbuf_en_wr=fbuf_wrea=0, fbuf_addr=0, fbuf_data=0.
- **Width rules:**
  - row_base+cx is computed in FBUF_ADDR_WIDTH bits; the maximum value is 307199 < 2^19 at the defaults.
  - Clamp comparisons use the full 12-bit inputs.

## Timing

- **Reset:** asynchronous. While rst_n=0, all outputs are 0, the state is IDLE, and counters are 0. Deassertion takes effect at the next clk edge.
- **Reset mid-fill:** aborts immediately. No fill_done pulse is produced; the remaining pixels are not written.
- **Pixel path latency:** pix_req sampled at edge E produces fbuf_en_wr=1 with that address and data during E→E+1.
- **Fill latency:** fill_start sampled at E0 → FILL from E0. The first fill write is visible during E1→E2, in the absence of pix_req.
- **Fill throughput:** a W×H rectangle with no contention gives W·H consecutive write cycles. fill_done is high in the cycle immediately after the last write cycle; fill_busy drops one cycle later.
- **Contention:** each pix_req during FILL adds exactly one cycle to the fill duration.
- **Empty rectangle:** fill_done is high during E0→E1 of the following cycle after DONE entry (i.e. the cycle after E0), with no write strobes.
- **Simultaneous events:** fill_start and pix_req on the same cycle in IDLE → the pixel write is issued and the fill command is captured. Both take effect.

## Test plan

- **Basic fill:** fill (1,1)-(2,2), color 0x5A, no contention → writes at 641, 642, 1281, 1282 on four consecutive cycles starting the second cycle after fill_start. fill_done is high in the following cycle; fill_busy is high from the cycle after fill_start until after fill_done.
- **Contention:** same fill with pix_req (addr 100, data 0x11) in the second fill cycle → sequence 641, 100(0x11), 642, 1281, 1282. fill_done is delayed by one cycle; no fill pixel is skipped.
- **Clamping:** fill (630,470)-(4095,4095), color 0xFF → 100 writes. The first address is 301430 and the last is 307199; row steps add 640.
- **Empty rectangle:** fill (5,5)-(4,9) → no fbuf_en_wr; fill_done pulses once, one cycle after capture.
- **Start while busy:** second fill_start (0,0)-(0,0) issued during a 4-pixel fill → ignored. Exactly 4 writes occur and exactly one fill_done pulse.
- **Reset mid-fill:** rst_n low during a 10×10 fill after 5 writes → all outputs 0 immediately and no fill_done. After release, a new fill (0,0)-(0,0) writes address 0 once.

Source files
------------

// File: rtl/gpu_fbuf_fill_arbiter_if.sv
// Bundles the decoder pixel path, fill command/status and BRAM port A of the fill arbiter.
// slave = the arbiter itself; master = whoever drives requests and observes the port.
interface gpu_fbuf_fill_arbiter_if #(
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int FBUF_DATA_WIDTH = 8
);
    logic                       pix_req;
    logic [FBUF_ADDR_WIDTH-1:0] pix_addr;
    logic [FBUF_DATA_WIDTH-1:0] pix_data;

    logic                       fill_start;
    logic [11:0]                fill_x0;
    logic [11:0]                fill_y0;
    logic [11:0]                fill_x1;
    logic [11:0]                fill_y1;
    logic [FBUF_DATA_WIDTH-1:0] fill_color;

    logic                       fill_busy;
    logic                       fill_done;

    logic                       fbuf_en_wr;
    logic                       fbuf_wrea;
    logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr;
    logic [FBUF_DATA_WIDTH-1:0] fbuf_data;

    modport master (
        output pix_req, pix_addr, pix_data,
        output fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
        input  fill_busy, fill_done,
        input  fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data
    );

    modport slave (
        input  pix_req, pix_addr, pix_data,
        input  fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
        output fill_busy, fill_done,
        output fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data
    );
endinterface

// File: rtl/gpu_fbuf_fill_arbiter.sv
// Owns framebuffer port A: decoder pixel writes always win, the rectangle-fill sequencer
// walks a clipped rectangle in raster order and stalls for one cycle per pixel write.
module gpu_fbuf_fill_arbiter #(
    parameter int FRAME_WIDTH_SCALED  = 640,
    parameter int FRAME_HEIGHT_SCALED = 480,
    parameter int FBUF_ADDR_WIDTH     = 19,
    parameter int FBUF_DATA_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gpu_fbuf_fill_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [11:0]                X_MAX  = 12'(FRAME_WIDTH_SCALED - 1);
    localparam logic [11:0]                Y_MAX  = 12'(FRAME_HEIGHT_SCALED - 1);
    localparam logic [FBUF_ADDR_WIDTH-1:0] STRIDE = FBUF_ADDR_WIDTH'(FRAME_WIDTH_SCALED);

    state_t                     state_q, state_d;
    logic [11:0]                x0_q, x0_d;
    logic [11:0]                x1_q, x1_d;
    logic [11:0]                y1_q, y1_d;
    logic [11:0]                cx_q, cx_d;
    logic [11:0]                cy_q, cy_d;
    logic [FBUF_ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [FBUF_DATA_WIDTH-1:0] color_q, color_d;
    logic                       last_q, last_d;
    logic                       fill_wr;

    logic                       en_q;
    logic [FBUF_ADDR_WIDTH-1:0] addr_q;
    logic [FBUF_DATA_WIDTH-1:0] data_q;

    logic [11:0] x0_c, y0_c, x1_c, y1_c;
    logic        rect_empty;

    always_comb begin
        x0_c       = (bus.fill_x0 > X_MAX) ? X_MAX : bus.fill_x0;
        x1_c       = (bus.fill_x1 > X_MAX) ? X_MAX : bus.fill_x1;
        y0_c       = (bus.fill_y0 > Y_MAX) ? Y_MAX : bus.fill_y0;
        y1_c       = (bus.fill_y1 > Y_MAX) ? Y_MAX : bus.fill_y1;
        rect_empty = (x0_c > x1_c) || (y0_c > y1_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            row_base_q <= '0;
            color_q    <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            row_base_q <= row_base_d;
            color_q    <= color_d;
            last_q     <= last_d;
        end
    end

    // last_q marks that the final pixel has been issued; FILL lingers one more cycle so that
    // fill_done lands in the cycle after the last write is visible on the port.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        row_base_d = row_base_q;
        color_d    = color_q;
        last_d     = last_q;
        fill_wr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.fill_start) begin
                    x0_d       = x0_c;
                    x1_d       = x1_c;
                    y1_d       = y1_c;
                    cx_d       = x0_c;
                    cy_d       = y0_c;
                    row_base_d = FBUF_ADDR_WIDTH'(y0_c) * STRIDE;
                    color_d    = bus.fill_color;
                    last_d     = 1'b0;
                    state_d    = rect_empty ? DONE : FILL;
                end
            end
            FILL: begin
                if (!bus.pix_req) begin
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        fill_wr = 1'b1;
                        if ((cx_q == x1_q) && (cy_q == y1_q)) begin
                            last_d = 1'b1;
                        end else if (cx_q < x1_q) begin
                            cx_d = cx_q + 12'd1;
                        end else begin
                            cx_d       = x0_q;
                            cy_d       = cy_q + 12'd1;
                            row_base_d = row_base_q + STRIDE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (bus.pix_req) begin
            en_q   <= 1'b1;
            addr_q <= bus.pix_addr;
            data_q <= bus.pix_data;
        end else if (fill_wr) begin
            en_q   <= 1'b1;
            addr_q <= row_base_q + FBUF_ADDR_WIDTH'(cx_q);
            data_q <= color_q;
        end else begin
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end
    end

    assign bus.fbuf_en_wr = en_q;
    assign bus.fbuf_wrea  = en_q;
    assign bus.fbuf_addr  = addr_q;
    assign bus.fbuf_data  = data_q;
    assign bus.fill_busy  = (state_q != IDLE);
    assign bus.fill_done  = (state_q == DONE);

endmodule

// File: tb/tb_gpu_fbuf_fill_arbiter.sv
// Directed bench for the framebuffer fill arbiter; port activity is sampled on the falling edge.
module tb_gpu_fbuf_fill_arbiter;
    typedef logic [30:0] vec_t; // {en_wr, wrea, addr[18:0], data[7:0], done, busy}

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    gpu_fbuf_fill_arbiter_if #(.FBUF_ADDR_WIDTH(19), .FBUF_DATA_WIDTH(8)) bus ();

    gpu_fbuf_fill_arbiter #(
        .FRAME_WIDTH_SCALED (640),
        .FRAME_HEIGHT_SCALED(480),
        .FBUF_ADDR_WIDTH    (19),
        .FBUF_DATA_WIDTH    (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t observe();
        return {bus.fbuf_en_wr, bus.fbuf_wrea, bus.fbuf_addr, bus.fbuf_data,
                bus.fill_done, bus.fill_busy};
    endfunction

    task automatic drive_fill(input logic [11:0] x0, input logic [11:0] y0,
                              input logic [11:0] x1, input logic [11:0] y1,
                              input logic [7:0] color);
        bus.fill_x0    = x0;
        bus.fill_y0    = y0;
        bus.fill_x1    = x1;
        bus.fill_y1    = y1;
        bus.fill_color = color;
        bus.fill_start = 1'b1;
    endtask

    task automatic test_reset();
        vec_t obs;
        #3 rst_n = 1'b0;
        #1 obs = observe();
        total++;
        if (obs !== 31'd0) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", obs, 31'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs = observe();
        total++;
        if (obs !== 31'd0) begin
            bad++;
            $display("FAIL reset_release_idle got=%h want=%h", obs, 31'd0);
        end
    endtask

    task automatic test_pixel();
        vec_t obs, exp;
        @(negedge clk);
        bus.pix_req  = 1'b1;
        bus.pix_addr = 19'd12345;
        bus.pix_data = 8'hC3;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.pix_req = 1'b0;
            obs = observe();
            exp = (i == 0) ? {2'b11, 19'd12345, 8'hC3, 2'b00} : 31'd0;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL pixel_write cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_basic_fill();
        vec_t        obs, exp;
        logic [18:0] a [4];
        a = '{19'd641, 19'd642, 19'd1281, 19'd1282};
        @(negedge clk);
        drive_fill(12'd1, 12'd1, 12'd2, 12'd2, 8'h5A);
        @(posedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.fill_start = 1'b0;
            obs = observe();
            if (i >= 1 && i <= 4) exp = {2'b11, a[i-1], 8'h5A, 1'b0, 1'b1};
            else                  exp = {2'b00, 19'd0, 8'd0, (i == 5), (i <= 5)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL basic_fill cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_contention();
        vec_t        obs, exp;
        logic [18:0] a [5];
        logic [7:0]  d [5];
        a = '{19'd641, 19'd100, 19'd642, 19'd1281, 19'd1282};
        d = '{8'h5A, 8'h11, 8'h5A, 8'h5A, 8'h5A};
        @(negedge clk);
        drive_fill(12'd1, 12'd1, 12'd2, 12'd2, 8'h5A);
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.fill_start = 1'b0;
            obs = observe();
            if (i >= 1 && i <= 5) exp = {2'b11, a[i-1], d[i-1], 1'b0, 1'b1};
            else                  exp = {2'b00, 19'd0, 8'd0, (i == 6), (i <= 6)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL contention cyc=%0d got=%h want=%h", i, obs, exp);
            end
            bus.pix_req  = (i == 1);
            bus.pix_addr = 19'd100;
            bus.pix_data = 8'h11;
        end
    endtask

    task automatic test_clamp();
        vec_t        obs, exp;
        logic [18:0] e_addr;
        logic [18:0] first_addr, last_addr;
        int          k;
        first_addr = '0;
        last_addr  = '0;
        @(negedge clk);
        drive_fill(12'd630, 12'd470, 12'd4095, 12'd4095, 8'hFF);
        @(posedge clk);
        for (int i = 0; i < 103; i++) begin
            @(negedge clk);
            bus.fill_start = 1'b0;
            obs = observe();
            if (i >= 1 && i <= 100) begin
                k      = i - 1;
                e_addr = 19'((470 + k / 10) * 640 + 630 + k % 10);
                exp    = {2'b11, e_addr, 8'hFF, 1'b0, 1'b1};
                if (i == 1)   first_addr = bus.fbuf_addr;
                if (i == 100) last_addr  = bus.fbuf_addr;
            end else begin
                exp = {2'b00, 19'd0, 8'd0, (i == 101), (i <= 101)};
            end
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL clamp_fill cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
        total++;
        if (first_addr !== 19'd301430) begin
            bad++;
            $display("FAIL clamp_first_addr got=%0d want=301430", first_addr);
        end
        total++;
        if (last_addr !== 19'd307199) begin
            bad++;
            $display("FAIL clamp_last_addr got=%0d want=307199", last_addr);
        end
    endtask

    task automatic test_empty_rect();
        vec_t obs, exp;
        @(negedge clk);
        drive_fill(12'd5, 12'd5, 12'd4, 12'd9, 8'hAA);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.fill_start = 1'b0;
            obs = observe();
            exp = {2'b00, 19'd0, 8'd0, (i == 0), (i == 0)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL empty_rect cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_start_while_busy();
        vec_t obs, exp;
        int   writes, dones;
        writes = 0;
        dones  = 0;
        @(negedge clk);
        drive_fill(12'd10, 12'd0, 12'd13, 12'd0, 8'h33);
        @(posedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.fill_start = 1'b0;
            obs = observe();
            if (i >= 1 && i <= 4) exp = {2'b11, 19'(9 + i), 8'h33, 1'b0, 1'b1};
            else                  exp = {2'b00, 19'd0, 8'd0, (i == 5), (i <= 5)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL busy_start cyc=%0d got=%h want=%h", i, obs, exp);
            end
            if (bus.fbuf_en_wr === 1'b1) writes++;
            if (bus.fill_done === 1'b1)  dones++;
            if (i == 1) drive_fill(12'd0, 12'd0, 12'd0, 12'd0, 8'h77);
        end
        total++;
        if (writes != 4 || dones != 1) begin
            bad++;
            $display("FAIL busy_start_counts got writes=%0d dones=%0d want writes=4 dones=1",
                     writes, dones);
        end
    endtask

    task automatic test_simultaneous();
        vec_t obs, exp;
        @(negedge clk);
        drive_fill(12'd3, 12'd0, 12'd3, 12'd0, 8'h22);
        bus.pix_req  = 1'b1;
        bus.pix_addr = 19'd7;
        bus.pix_data = 8'h66;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.fill_start = 1'b0;
            bus.pix_req    = 1'b0;
            obs = observe();
            case (i)
                0:       exp = {2'b11, 19'd7, 8'h66, 1'b0, 1'b1};
                1:       exp = {2'b11, 19'd3, 8'h22, 1'b0, 1'b1};
                2:       exp = {2'b00, 19'd0, 8'd0, 1'b1, 1'b1};
                default: exp = 31'd0;
            endcase
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL simultaneous cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        vec_t obs, exp;
        @(negedge clk);
        drive_fill(12'd0, 12'd0, 12'd9, 12'd9, 8'h44);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.fill_start = 1'b0;
            obs = observe();
            if (i >= 1) exp = {2'b11, 19'(i - 1), 8'h44, 1'b0, 1'b1};
            else        exp = {2'b00, 19'd0, 8'd0, 1'b0, 1'b1};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_mid_fill_pre cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
        rst_n = 1'b0;
        #1 obs = observe();
        total++;
        if (obs !== 31'd0) begin
            bad++;
            $display("FAIL reset_mid_fill_immediate got=%h want=%h", obs, 31'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            obs = observe();
            total++;
            if (obs !== 31'd0) begin
                bad++;
                $display("FAIL reset_mid_fill_held cyc=%0d got=%h want=%h", i, obs, 31'd0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = observe();
            total++;
            if (obs !== 31'd0) begin
                bad++;
                $display("FAIL reset_mid_fill_no_done cyc=%0d got=%h want=%h", i, obs, 31'd0);
            end
        end
        drive_fill(12'd0, 12'd0, 12'd0, 12'd0, 8'h99);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.fill_start = 1'b0;
            obs = observe();
            case (i)
                0:       exp = {2'b00, 19'd0, 8'd0, 1'b0, 1'b1};
                1:       exp = {2'b11, 19'd0, 8'h99, 1'b0, 1'b1};
                2:       exp = {2'b00, 19'd0, 8'd0, 1'b1, 1'b1};
                default: exp = 31'd0;
            endcase
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_mid_fill_refill cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b1;
        bus.pix_req    = 1'b0;
        bus.pix_addr   = '0;
        bus.pix_data   = '0;
        bus.fill_start = 1'b0;
        bus.fill_x0    = '0;
        bus.fill_y0    = '0;
        bus.fill_x1    = '0;
        bus.fill_y1    = '0;
        bus.fill_color = '0;

        test_reset();
        test_pixel();
        test_basic_fill();
        test_contention();
        test_clamp();
        test_empty_rect();
        test_start_while_busy();
        test_simultaneous();
        test_reset_mid_fill();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
